change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream stage of the vending machine controller. Captures one transaction result (item code plus per-denomination change counts) and drives the physical mechanisms. It pulses the item vend solenoid first, then ejects coins one at a time, largest denomination first. Each mechanism action uses a req/ack handshake with a timeout.

## Interface
- `GAP_CYCLES`, default 4: idle cycles between successive mechanism requests (min 1).
- `TIMEOUT`, default 1000: cycles to wait for an ack before declaring fault (min 2).
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: capture transaction; accepted only when `ready`=1.
- `item_dispensed`  in  3: 0–5 item code; 6 = insufficient funds; 7 = rejected/refund.
- `change_dollar`  in  1: dollar coins to return.
- `change_quarters`  in  2: quarters to return.
- `change_dimes`  in  4: dimes to return.
- `change_nickels`  in  5: nickels to return.
- `ready`  out  1: idle and able to accept `load`.
- `vend_req`  out  1: vend request, held until `vend_ack`.
- `vend_item`  out  3: item code, valid while `vend_req`=1.
- `vend_ack`  in  1: vend mechanism done.
- `coin_req`  out  1: coin eject request, held until `coin_ack`.
- `coin_type`  out  2: 3 = dollar, 2 = quarter, 1 = dime, 0 = nickel; valid while `coin_req`=1.
- `coin_ack`  in  1: coin ejected.
- `refund_cents`  out  8: running cents ejected in current transaction.
- `done`  out  1: one-cycle pulse when the transaction completes.
- `fault`  out  1: sticky; set on timeout.

## Operation
- States: IDLE, VEND, DOLLAR, QUARTER, DIME, NICKEL, GAP, DONE, FAULT.
- IDLE:
  - `ready`=1.
  - On `load`, latch all inputs into internal counters and clear `refund_cents`.
  - If the latched item ≤ 5, go to VEND; otherwise go to the first denomination with a non-zero count, or DONE if all counts are zero.
- VEND: `vend_req`=1 with the latched item. On `vend_ack`, drop the request and go to GAP.
- Coin states (DOLLAR, QUARTER, DIME, NICKEL):
  - `coin_req`=1 with the matching `coin_type`.
  - On `coin_ack`: decrement that counter, add 100/25/10/5 to `refund_cents`, then go to GAP.
- GAP:
  - Wait `GAP_CYCLES` cycles.
  - Then go to the highest denomination whose counter is non-zero, in order dollar > quarter > dime > nickel; or DONE if all are zero.
- DONE: `done`=1 for one cycle, then IDLE.
- Timeout:
  - A counter runs in VEND and in the coin states; it is cleared on entry to each of those states.
  - Reaching `TIMEOUT` with no ack → FAULT.
- FAULT:
  - `fault`=1; all requests deasserted; `ready`=0.
  - Exited only by `reset_n`.
- `refund_cents` saturates at 255 and is never negative.
- Counts are taken as given, with no range check: nickels up to 31, dimes up to 15.

## Timing
- Reset values: state IDLE, `ready`=1, `vend_req`=0, `coin_req`=0, `vend_item`=0, `coin_type`=0, `refund_cents`=0, `done`=0, `fault`=0; all counters 0.
- Outputs are registered.
- Requests rise the cycle after the state is entered, and fall the cycle after the ack is sampled.
- `load` while `ready`=0 is ignored; nothing is captured.
- `load` and capture happen in the same edge; `ready` falls the next cycle.
- An ack that arrives without a matching request is ignored.
- An ack in the same cycle the timeout expires counts as success; the ack wins.
- Latency for an all-zero load with item 6: `load` edge → `done` two cycles later.
- `reset_n` assertion mid-handshake: all outputs go immediately to reset values, with no completion pulse.
- Back-to-back: `load` is accepted in the cycle after `done`.

## Structure
- Shared package holds:
  - State enum.
  - Coin type encodings: `COIN_NICKEL`, `COIN_DIME`, `COIN_QUARTER`, `COIN_DOLLAR`.
  - Cents values: 5, 10, 25, 100.
  - Item codes `ITEM_NOFUNDS`=6 and `ITEM_REJECT`=7, shared with the vending machine controller.
- One natural sub-module, `handshake_timer`, shared by the vend and coin paths. It provides:
  - req/ack tracking;
  - the timeout counter;
  - the inter-request gap counter.

## Test plan
- Item 3 with change 0/0/0/0 → one `vend_req` with `vend_item`=3, no `coin_req`, `done` pulse, `refund_cents`=0.
- Item 5 with dollar 1, quarters 2, dimes 1, nickels 1:
  - → `vend_req` first, then `coin_type` sequence 3, 2, 2, 1, 0;
  - each request is separated by ≥`GAP_CYCLES` idle cycles;
  - final `refund_cents`=165.
- Item 7 with quarters 3, nickels 1:
  - → no `vend_req`; coin types 2, 2, 2, 0;
  - `refund_cents`=80; `done` pulse.
- Withhold `coin_ack` for `TIMEOUT` cycles → `fault`=1 and `coin_req`=0 from the next cycle; a later `load` is ignored; `reset_n` clears it.
- Pulse `load` while busy, and pulse `coin_ack` while no request is outstanding → no change to counters, sequence, or `refund_cents`.
- Assert `reset_n` low mid-sequence, then release and load item 4 with change 0 → clean IDLE with all outputs 0; the new transaction completes normally.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state type, coin type encodings,
// coin values in cents and the special item codes shared with the vending controller.
package change_dispenser_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StVend,
    StDollar,
    StQuarter,
    StDime,
    StNickel,
    StGap,
    StDone,
    StFault
  } state_e;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;
  localparam logic [1:0] COIN_DOLLAR  = 2'd3;

  localparam logic [7:0] CENTS_NICKEL  = 8'd5;
  localparam logic [7:0] CENTS_DIME    = 8'd10;
  localparam logic [7:0] CENTS_QUARTER = 8'd25;
  localparam logic [7:0] CENTS_DOLLAR  = 8'd100;

  // Item codes 0..5 are real products; these two mean "nothing to vend".
  localparam logic [2:0] ITEM_MAX     = 3'd5;
  localparam logic [2:0] ITEM_NOFUNDS = 3'd6;
  localparam logic [2:0] ITEM_REJECT  = 3'd7;

  // Largest denomination still owed, or StDone when nothing is left.
  function automatic state_e next_coin_state(input logic       dollar,
                                             input logic [1:0] quarters,
                                             input logic [3:0] dimes,
                                             input logic [4:0] nickels);
    state_e st;
    if (dollar)                st = StDollar;
    else if (quarters != '0)   st = StQuarter;
    else if (dimes != '0)      st = StDime;
    else if (nickels != '0)    st = StNickel;
    else                       st = StDone;
    return st;
  endfunction

  function automatic logic [1:0] coin_type_of(input state_e st);
    logic [1:0] t;
    case (st)
      StDollar:  t = COIN_DOLLAR;
      StQuarter: t = COIN_QUARTER;
      StDime:    t = COIN_DIME;
      default:   t = COIN_NICKEL;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] coin_cents_of(input state_e st);
    logic [7:0] c;
    case (st)
      StDollar:  c = CENTS_DOLLAR;
      StQuarter: c = CENTS_QUARTER;
      StDime:    c = CENTS_DIME;
      default:   c = CENTS_NICKEL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/change_dispenser_handshake_timer.sv
// handshake_timer: request/ack qualification, ack timeout counter and inter-request gap
// counter, shared by the vend and coin paths of change_dispenser.
//   vend_req/coin_req   : registered requests currently driven by the parent
//   vend_ack/coin_ack   : acks from the mechanisms
//   busy                : parent sits in a handshake state (vend or coin)
//   leave               : parent leaves its current state at the next edge
//   in_gap              : parent sits in the gap state
//   ack_ok              : an ack matching an outstanding request
//   timeout             : timeout expires at this edge with no ack
//   gap_done            : last cycle of the gap
module handshake_timer #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic vend_req,
  input  logic vend_ack,
  input  logic coin_req,
  input  logic coin_ack,
  input  logic busy,
  input  logic leave,
  input  logic in_gap,
  output logic ack_ok,
  output logic timeout,
  output logic gap_done
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    // An ack only counts against a request that is actually being driven.
    ack_ok   = (vend_req & vend_ack) | (coin_req & coin_ack);
    // The ack wins when it lands on the expiring cycle.
    timeout  = busy && (tmo_q == TMO_LAST) && !ack_ok;
    gap_done = in_gap && (gap_q == GAP_LAST);
    // Handshake states are never adjacent, so the counter is always zero on entry.
    tmo_d    = (busy && !leave) ? tmo_q + TW'(1) : '0;
    gap_d    = (in_gap && !gap_done) ? gap_q + GW'(1) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      gap_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: captures one transaction result, pulses the vend solenoid, then ejects
// change one coin at a time (largest first) through req/ack handshakes with timeout.
//   load, item_dispensed, change_*  : transaction capture (only while ready)
//   ready                           : idle, load accepted
//   vend_req/vend_item/vend_ack     : vend mechanism handshake
//   coin_req/coin_type/coin_ack     : coin ejector handshake
//   refund_cents                    : saturating running total ejected this transaction
//   done                            : one-cycle completion pulse
//   fault                           : sticky timeout flag, cleared only by reset_n
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] item_dispensed,
  input  logic       change_dollar,
  input  logic [1:0] change_quarters,
  input  logic [3:0] change_dimes,
  input  logic [4:0] change_nickels,
  output logic       ready,
  output logic       vend_req,
  output logic [2:0] vend_item,
  input  logic       vend_ack,
  output logic       coin_req,
  output logic [1:0] coin_type,
  input  logic       coin_ack,
  output logic [7:0] refund_cents,
  output logic       done,
  output logic       fault
);

  state_e     state_q, state_d;
  logic [2:0] item_q, item_d;
  logic       dollar_q, dollar_d;
  logic [1:0] quarters_q, quarters_d;
  logic [3:0] dimes_q, dimes_d;
  logic [4:0] nickels_q, nickels_d;
  logic [7:0] refund_q, refund_d;
  logic       ready_q, ready_d;
  logic       vend_req_q, vend_req_d;
  logic [2:0] vend_item_q, vend_item_d;
  logic       coin_req_q, coin_req_d;
  logic [1:0] coin_type_q, coin_type_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;

  logic       busy, in_gap, leave;
  logic       ack_ok, timeout, gap_done;
  logic [8:0] refund_sum;

  handshake_timer #(
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .vend_req(vend_req_q),
    .vend_ack(vend_ack),
    .coin_req(coin_req_q),
    .coin_ack(coin_ack),
    .busy    (busy),
    .leave   (leave),
    .in_gap  (in_gap),
    .ack_ok  (ack_ok),
    .timeout (timeout),
    .gap_done(gap_done)
  );

  always_comb begin
    busy   = state_q inside {StVend, StDollar, StQuarter, StDime, StNickel};
    in_gap = (state_q == StGap);

    state_d    = state_q;
    item_d     = item_q;
    dollar_d   = dollar_q;
    quarters_d = quarters_q;
    dimes_d    = dimes_q;
    nickels_d  = nickels_q;
    refund_d   = refund_q;
    refund_sum = {1'b0, refund_q} + {1'b0, coin_cents_of(state_q)};

    unique case (state_q)
      StIdle: begin
        if (load) begin
          item_d     = item_dispensed;
          dollar_d   = change_dollar;
          quarters_d = change_quarters;
          dimes_d    = change_dimes;
          nickels_d  = change_nickels;
          refund_d   = '0;
          state_d    = (item_dispensed <= ITEM_MAX) ? StVend
                     : next_coin_state(change_dollar, change_quarters, change_dimes,
                                       change_nickels);
        end
      end
      StVend: begin
        if (ack_ok)       state_d = StGap;
        else if (timeout) state_d = StFault;
      end
      StDollar, StQuarter, StDime, StNickel: begin
        if (ack_ok) begin
          state_d  = StGap;
          refund_d = refund_sum[8] ? 8'hFF : refund_sum[7:0];
          case (state_q)
            StDollar:  dollar_d   = 1'b0;
            StQuarter: quarters_d = quarters_q - 2'd1;
            StDime:    dimes_d    = dimes_q - 4'd1;
            default:   nickels_d  = nickels_q - 5'd1;
          endcase
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StGap: begin
        if (gap_done) state_d = next_coin_state(dollar_q, quarters_q, dimes_q, nickels_q);
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    leave = (state_d != state_q);

    // Requests rise one cycle after state entry (state_q already there) and drop on the
    // edge that samples the ack or the timeout.
    ready_d     = (state_d == StIdle);
    vend_req_d  = (state_q == StVend) && !leave;
    vend_item_d = vend_req_d ? item_q : '0;
    coin_req_d  = busy && (state_q != StVend) && !leave;
    coin_type_d = coin_req_d ? coin_type_of(state_q) : COIN_NICKEL;
    done_d      = (state_q == StDone);
    fault_d     = fault_q | (state_d == StFault);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      item_q      <= '0;
      dollar_q    <= 1'b0;
      quarters_q  <= '0;
      dimes_q     <= '0;
      nickels_q   <= '0;
      refund_q    <= '0;
      ready_q     <= 1'b1;
      vend_req_q  <= 1'b0;
      vend_item_q <= '0;
      coin_req_q  <= 1'b0;
      coin_type_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      dollar_q    <= dollar_d;
      quarters_q  <= quarters_d;
      dimes_q     <= dimes_d;
      nickels_q   <= nickels_d;
      refund_q    <= refund_d;
      ready_q     <= ready_d;
      vend_req_q  <= vend_req_d;
      vend_item_q <= vend_item_d;
      coin_req_q  <= coin_req_d;
      coin_type_q <= coin_type_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign ready        = ready_q;
  assign vend_req     = vend_req_q;
  assign vend_item    = vend_item_q;
  assign coin_req     = coin_req_q;
  assign coin_type    = coin_type_q;
  assign refund_cents = refund_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. A reference model lists the expected mechanism
// actions and refund total from the transaction arithmetic; a responder acks requests
// after random delays and optionally injects stray acks and loads.
module tb_change_dispenser;

  localparam int unsigned GAP = 3;
  localparam int unsigned TMO = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic [2:0] item_dispensed = '0;
  logic       change_dollar = 1'b0;
  logic [1:0] change_quarters = '0;
  logic [3:0] change_dimes = '0;
  logic [4:0] change_nickels = '0;
  logic       vend_ack = 1'b0;
  logic       coin_ack = 1'b0;
  logic       ready, vend_req, coin_req, done, fault;
  logic [2:0] vend_item;
  logic [1:0] coin_type;
  logic [7:0] refund_cents;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];

  always #5 clock = ~clock;

  change_dispenser #(
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .load           (load),
    .item_dispensed (item_dispensed),
    .change_dollar  (change_dollar),
    .change_quarters(change_quarters),
    .change_dimes   (change_dimes),
    .change_nickels (change_nickels),
    .ready          (ready),
    .vend_req       (vend_req),
    .vend_item      (vend_item),
    .vend_ack       (vend_ack),
    .coin_req       (coin_req),
    .coin_type      (coin_type),
    .coin_ack       (coin_ack),
    .refund_cents   (refund_cents),
    .done           (done),
    .fault          (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected action list: 100+item for a vend, else coin type; cents saturate at 255.
  task automatic model(input int item, input int d, input int q, input int di, input int n,
                       output int cents);
    exp_q.delete();
    if (item <= 5) exp_q.push_back(100 + item);
    repeat (d) exp_q.push_back(3);
    repeat (q) exp_q.push_back(2);
    repeat (di) exp_q.push_back(1);
    repeat (n) exp_q.push_back(0);
    cents = d * 100 + q * 25 + di * 10 + n * 5;
    if (cents > 255) cents = 255;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, ready, 1);
    check({name, "_vend_req"}, vend_req, 0);
    check({name, "_vend_item"}, vend_item, 0);
    check({name, "_coin_req"}, coin_req, 0);
    check({name, "_coin_type"}, coin_type, 0);
    check({name, "_refund"}, refund_cents, 0);
    check({name, "_done"}, done, 0);
    check({name, "_fault"}, fault, 0);
  endtask

  // Called at a negedge; returns at the negedge after the done pulse.
  task automatic run_txn(input string name, input int item, input int d, input int q,
                         input int di, input int n, input int max_delay, input int forced_wait,
                         input bit noise, output int done_cyc);
    int  cents, cyc, last_fall, wait_n;
    bit  prev_req, cur_req, ack_hold, first, finished;
    model(item, d, q, di, n, cents);
    obs_q.delete();
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check({name, "_ready_before_load"}, ready, 1);
    item_dispensed  = 3'(item);
    change_dollar   = 1'(d);
    change_quarters = 2'(q);
    change_dimes    = 4'(di);
    change_nickels  = 5'(n);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    check({name, "_ready_falls"}, ready, 0);
    check({name, "_refund_cleared"}, refund_cents, 0);
    prev_req = 0; ack_hold = 0; first = 1; finished = 0; last_fall = 0; wait_n = 0;
    done_cyc = -1;
    for (cyc = 1; cyc < 4000 && !finished; cyc++) begin
      cur_req = vend_req | coin_req;
      if (ack_hold) begin
        check({name, "_req_drops_after_ack"}, cur_req, 0);
        ack_hold = 0;
      end
      vend_ack = 1'b0;
      coin_ack = 1'b0;
      load     = 1'b0;
      if (done) begin
        done_cyc = cyc;
        finished = 1;
      end
      if (cur_req && !prev_req) begin
        obs_q.push_back(vend_req ? 100 + int'(vend_item) : int'(coin_type));
        if (!first) check({name, "_gap_idle"}, (cyc - last_fall) >= GAP, 1);
        first  = 0;
        wait_n = (forced_wait >= 0) ? forced_wait : $urandom_range(0, max_delay);
      end
      if (!cur_req && prev_req) last_fall = cyc;
      if (cur_req) begin
        if (wait_n == 0) begin
          vend_ack = vend_req;
          coin_ack = coin_req;
          ack_hold = 1;
        end else begin
          wait_n--;
        end
      end else if (noise && !finished && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) coin_ack = 1'b1;
        else vend_ack = 1'b1;
        if (!ready) begin
          load            = 1'b1;
          item_dispensed  = 3'($urandom);
          change_dollar   = 1'($urandom);
          change_quarters = 2'($urandom);
          change_dimes    = 4'($urandom);
          change_nickels  = 5'($urandom);
        end
      end
      prev_req = cur_req;
      if (!finished) @(negedge clock);
    end
    check({name, "_completed"}, finished, 1);
    check({name, "_refund"}, refund_cents, cents);
    check({name, "_seq_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, "_seq_item"}, obs_q[i], exp_q[i]);
    check({name, "_no_fault"}, fault, 0);
    @(negedge clock);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_ready_after"}, ready, 1);
  endtask

  initial begin
    int dc, n_high, c;
    bit acked;

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("after_reset");

    run_txn("item3", 3, 0, 0, 0, 0, 2, -1, 0, dc);
    run_txn("item5", 5, 1, 2, 1, 1, 3, -1, 0, dc);
    run_txn("item7", 7, 0, 3, 0, 1, 1, -1, 0, dc);
    // Back-to-back: loads right after the previous done cycle
    run_txn("nofunds", 6, 0, 0, 0, 0, 0, -1, 0, dc);
    check("nofunds_latency", dc, 2);
    // Ack on the last cycle before expiry must still succeed
    run_txn("late_ack", 0, 1, 0, 0, 1, 0, TMO - 2, 0, dc);
    run_txn("saturate", 7, 1, 3, 15, 31, 2, -1, 1, dc);
    run_txn("noisy", 2, 0, 1, 2, 1, 4, -1, 1, dc);
    for (int t = 0; t < 5; t++)
      run_txn("random", $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 6), $urandom_range(0, 6), 6, -1, 1, dc);

    // Timeout: withhold coin_ack
    item_dispensed = 3'd7; change_dollar = 1'b0; change_quarters = 2'd1;
    change_dimes = 4'd0; change_nickels = 5'd0;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    n_high = 0;
    for (c = 0; c < int'(TMO) + 10 && !fault; c++) begin
      if (coin_req) n_high++;
      @(negedge clock);
    end
    check("fault_set", fault, 1);
    check("fault_coin_req_low", coin_req, 0);
    check("fault_ready_low", ready, 0);
    check("fault_req_cycles", (n_high >= int'(TMO) - 1) && (n_high <= int'(TMO)), 1);
    item_dispensed = 3'd2; load = 1'b1; coin_ack = 1'b1;
    @(negedge clock);
    load = 1'b0; coin_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("fault_load_ignored_vend", vend_req, 0);
    check("fault_sticky", fault, 1);
    check("fault_still_not_ready", ready, 0);
    check("fault_refund", refund_cents, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("fault_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset mid-sequence, after the dollar has been ejected
    item_dispensed = 3'd5; change_dollar = 1'b1; change_quarters = 2'd2;
    change_dimes = 4'd1; change_nickels = 5'd1;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    acked = 0;
    for (c = 0; c < 400 && !(coin_req && refund_cents != 0); c++) begin
      vend_ack = 1'b0; coin_ack = 1'b0;
      if (!acked && (vend_req || coin_req)) begin
        vend_ack = vend_req; coin_ack = coin_req; acked = 1;
      end else begin
        acked = 0;
      end
      @(negedge clock);
    end
    check("midreset_reached", coin_req && refund_cents == 8'd100 && coin_type == 2'd2, 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    check("midreset_no_done", done, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset_outputs("midreset_released");
    run_txn("after_reset", 4, 0, 0, 0, 0, 2, -1, 0, dc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
